// File: rtl/bus_pkg.sv
// bus_pkg
// Shared types and constants for the core memory bus arbiter.
//   bus_request_t : one memory request (address, direction, store data, byte enables)
//   arb_state_t   : arbiter transaction state
//   REQ_FETCH / REQ_EXEC : requester indices into the per-requester port vectors
`timescale 1ns/1ps

package bus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_request_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_EXEC  = 1'b1;

  // Bundle one requester's loose port fields into a request record.
  function automatic bus_request_t make_request(
    input logic [31:0] addr,
    input logic        write,
    input logic [31:0] wdata,
    input logic [3:0]  wmask
  );
    bus_request_t r;
    r.addr  = addr;
    r.write = write;
    r.wdata = wdata;
    r.wmask = wmask;
    return r;
  endfunction

endpackage

// File: rtl/bus_grant_policy.sv
// bus_grant_policy
// Chooses which requester wins an arbitration and tracks fetch starvation.
// Execute has priority; after STARVE_LIMIT consecutive execute grants made
// while fetch was waiting, fetch wins the next contended arbitration.
// Ports:
//   clock, nreset : core clock, asynchronous active-low reset
//   req_valid     : per-requester request present
//   flush         : pipeline flush; fetch is not eligible while it is high
//   idle          : arbiter is in IDLE and may grant this cycle
//   grant         : a winner is granted this cycle
//   winner        : index of the granted requester (valid with grant)
`timescale 1ns/1ps

module bus_grant_policy
  import bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic [1:0] req_valid,
  input  logic       flush,
  input  logic       idle,
  output logic       grant,
  output logic       winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       fetch_ok;
  logic       exec_ok;

  assign fetch_ok = req_valid[REQ_FETCH] & ~flush;
  assign exec_ok  = req_valid[REQ_EXEC];

  always_comb begin
    winner = REQ_FETCH;
    grant  = idle & (fetch_ok | exec_ok);
    if (fetch_ok && exec_ok) begin
      winner = (starve_cnt == LIMIT) ? REQ_FETCH : REQ_EXEC;
    end else if (exec_ok) begin
      winner = REQ_EXEC;
    end
  end

  // The counter only measures starvation while fetch is actually asking: any
  // idle cycle without a fetch request, or a fetch grant, resets it. An
  // execute grant counts even if fetch was masked by flush that cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      starve_cnt <= 4'd0;
    end else if (grant && (winner == REQ_FETCH)) begin
      starve_cnt <= 4'd0;
    end else if (idle && !req_valid[REQ_FETCH]) begin
      starve_cnt <= 4'd0;
    end else if (grant && (winner == REQ_EXEC) && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares the core memory bus between fetch (requester 0) and execute
// (requester 1). One transaction at a time: accept in IDLE, offer it to the
// bus in ISSUE, wait for the bus response in WAIT and route it back.
// A flush discards an in-flight fetch response; execute is never dropped.
// Ports:
//   clock, nreset        : core clock, asynchronous active-low reset
//   flush                : pipeline flush
//   req_valid/addr/write/wdata/wmask : per-requester request fields
//   req_ready            : request accepted this cycle (one-hot or zero)
//   resp_valid           : per-requester response pulse
//   resp_rdata           : load data, meaningful only with resp_valid
//   bus_valid/addr/write/wdata/wmask : transaction offered to the bus
//   bus_ready            : bus accepts the offered transaction
//   bus_resp_valid       : bus completes the transaction
//   bus_rdata            : bus load data
//   busy                 : arbiter not IDLE
//   owner                : requester owning the current transaction
`timescale 1ns/1ps

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0]       req_write,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][3:0]  req_wmask,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             bus_valid,
  output logic [31:0]      bus_addr,
  output logic             bus_write,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_wmask,
  input  logic             bus_ready,
  input  logic             bus_resp_valid,
  input  logic [31:0]      bus_rdata,
  output logic             busy,
  output logic             owner
);

  arb_state_t   state;
  arb_state_t   next_state;
  bus_request_t bus_req;
  bus_request_t req_sel;
  logic         drop;
  logic         grant;
  logic         winner;
  logic         fetch_flushed;

  bus_grant_policy #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_policy (
    .clock    (clock),
    .nreset   (nreset),
    .req_valid(req_valid),
    .flush    (flush),
    .idle     (state == IDLE),
    .grant    (grant),
    .winner   (winner)
  );

  assign req_sel = make_request(req_addr[winner], req_write[winner],
                                req_wdata[winner], req_wmask[winner]);

  // A flush arriving in the same cycle as the response must already suppress
  // it, before drop has had a chance to register.
  assign fetch_flushed = drop | (flush & (owner == REQ_FETCH));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The accepted request is captured once and held unchanged for the bus
  // until the next acceptance.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      bus_req <= '0;
      owner   <= REQ_FETCH;
    end else if (grant) begin
      bus_req <= req_sel;
      owner   <= winner;
    end
  end

  // Clearing on the way back to IDLE wins over setting, so a drop never
  // leaks into the next transaction.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      drop <= 1'b0;
    end else if ((state != IDLE) && (next_state == IDLE)) begin
      drop <= 1'b0;
    end else if ((state != IDLE) && flush && (owner == REQ_FETCH)) begin
      drop <= 1'b1;
    end
  end

  // Next-state and handshake outputs. A bus response outside WAIT is a
  // protocol error and simply falls through the IDLE/ISSUE branches.
  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_rdata = 32'd0;
    case (state)
      IDLE: begin
        if (grant) begin
          req_ready[winner] = 1'b1;
          next_state        = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_ready) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus_resp_valid) begin
          if (!fetch_flushed) begin
            resp_valid[owner] = 1'b1;
            resp_rdata        = bus_rdata;
          end
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign bus_addr  = bus_req.addr;
  assign bus_write = bus_req.write;
  assign bus_wdata = bus_req.wdata;
  assign bus_wmask = bus_req.wmask;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed bench for bus_arbiter with STARVE_LIMIT = 4. Expected responses
// are queued when a transaction is driven and matched when resp_valid fires.
`timescale 1ns/1ps

module tb_bus_arbiter;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] data;
  } resp_t;

  logic             clock = 1'b0;
  logic             nreset;
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wmask;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [31:0]      resp_rdata;
  logic             bus_valid;
  logic [31:0]      bus_addr;
  logic             bus_write;
  logic [31:0]      bus_wdata;
  logic [3:0]       bus_wmask;
  logic             bus_ready;
  logic             bus_resp_valid;
  logic [31:0]      bus_rdata;
  logic             busy;
  logic             owner;

  int    checks = 0;
  int    errors = 0;
  resp_t expQ[$];

  logic [31:0] expAddr;
  logic        expWrite;
  logic [31:0] expWdata;
  logic [3:0]  expWmask;
  logic        expOwner;
  logic        grantOrder[10];

  bus_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clock         (clock),
    .nreset        (nreset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_write     (req_write),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .bus_valid     (bus_valid),
    .bus_addr      (bus_addr),
    .bus_write     (bus_write),
    .bus_wdata     (bus_wdata),
    .bus_wmask     (bus_wmask),
    .bus_ready     (bus_ready),
    .bus_resp_valid(bus_resp_valid),
    .bus_rdata     (bus_rdata),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic fl);
    req_valid = valid;
    flush     = fl;
    #2;
  endtask

  // Checks the acceptance strobe and records what the bus should carry.
  task automatic expectGrant(input logic who, input string tag);
    checkOutput(tag, 32'(req_ready), who ? 32'h2 : 32'h1);
    expAddr  = req_addr[who];
    expWrite = req_write[who];
    expWdata = req_wdata[who];
    expWmask = req_wmask[who];
    expOwner = who;
  endtask

  // Runs the bus side of an accepted transaction: bus_ready after `delay`
  // ISSUE cycles, then the response in the very next cycle.
  task automatic serviceBus(input logic [1:0] validAfter, input int delay,
                            input logic [31:0] rdata, input logic wantResp);
    tick();
    req_valid = validAfter;
    flush     = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) bus_ready = 1'b1;
      #1;
      checkOutput("issue_valid", 32'(bus_valid), 32'h1);
      checkOutput("issue_addr", bus_addr, expAddr);
      checkOutput("issue_write", 32'(bus_write), 32'(expWrite));
      checkOutput("issue_wdata", bus_wdata, expWdata);
      checkOutput("issue_wmask", 32'(bus_wmask), 32'(expWmask));
      checkOutput("issue_owner", 32'(owner), 32'(expOwner));
      tick();
    end
    bus_ready = 1'b0;
    if (wantResp) expQ.push_back({expOwner ? 2'b10 : 2'b01, rdata});
    bus_resp_valid = 1'b1;
    bus_rdata      = rdata;
    #1;
    checkOutput("wait_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("wait_busy", 32'(busy), 32'h1);
    tick();
    bus_resp_valid = 1'b0;
    bus_rdata      = 32'd0;
  endtask

  // Matches every response pulse against the oldest queued expectation.
  always @(negedge clock) begin
    resp_t e;
    if (nreset && (resp_valid !== 2'b00)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_resp observed=%0h expected=none", resp_valid);
      end else begin
        e = expQ.pop_front();
        checkOutput("resp_valid", 32'(resp_valid), 32'(e.who));
        checkOutput("resp_rdata", resp_rdata, e.data);
      end
    end
    if (nreset && busy) begin
      checkOutput("ready_outside_idle", 32'(req_ready), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    nreset         = 1'b0;
    flush          = 1'b0;
    req_valid      = 2'b00;
    req_addr       = '0;
    req_write      = 2'b00;
    req_wdata      = '0;
    req_wmask      = '0;
    bus_ready      = 1'b0;
    bus_resp_valid = 1'b0;
    bus_rdata      = 32'd0;
    grantOrder     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    #2;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    tick();
    tick();
    nreset = 1'b1;
    tick();

    // Fetch-only load.
    $display("[TB] fetch-only load");
    req_addr[0] = 32'h10;
    applyStimulus(2'b01, 1'b0);
    expectGrant(1'b0, "fetch_grant");
    serviceBus(2'b00, 0, 32'hDEADBEEF, 1'b1);
    #1;
    checkOutput("fetch_done_busy", 32'(busy), 32'h0);

    // Both requesters continuously valid: starvation limit order.
    $display("[TB] contended grant order");
    req_addr[0] = 32'h1000;
    req_addr[1] = 32'h2000;
    applyStimulus(2'b11, 1'b0);
    for (int g = 0; g < 10; g++) begin
      expectGrant(grantOrder[g], $sformatf("order_%0d", g));
      serviceBus(2'b11, 0, 32'hA000 + 32'(g), 1'b1);
      #2;
    end
    req_valid = 2'b00;
    tick();

    // Execute store with a slow bus_ready.
    $display("[TB] execute store");
    req_addr[1]  = 32'h200;
    req_write[1] = 1'b1;
    req_wdata[1] = 32'h12345678;
    req_wmask[1] = 4'b0011;
    applyStimulus(2'b10, 1'b0);
    expectGrant(1'b1, "store_grant");
    serviceBus(2'b00, 3, 32'h0, 1'b1);
    req_write[1] = 1'b0;
    req_wdata[1] = 32'h0;
    req_wmask[1] = 4'b0;

    // Flush pulsed while a fetch waits for its response.
    $display("[TB] flush during fetch wait");
    req_addr[0] = 32'h40;
    applyStimulus(2'b01, 1'b0);
    expectGrant(1'b0, "flush_fetch_grant");
    tick();
    req_valid = 2'b00;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    flush     = 1'b1;
    tick();
    flush          = 1'b0;
    bus_resp_valid = 1'b1;
    bus_rdata      = 32'hBAD0BAD0;
    #1;
    checkOutput("flush_drop", 32'(resp_valid), 32'h0);
    tick();
    bus_resp_valid = 1'b0;
    checkOutput("flush_idle", 32'(busy), 32'h0);
    req_addr[1] = 32'h300;
    applyStimulus(2'b10, 1'b0);
    expectGrant(1'b1, "exec_after_flush");
    serviceBus(2'b00, 0, 32'hCAFEF00D, 1'b1);

    // Flush arriving together with the fetch response.
    $display("[TB] flush with response");
    applyStimulus(2'b01, 1'b0);
    expectGrant(1'b0, "same_cycle_grant");
    tick();
    req_valid = 2'b00;
    bus_ready = 1'b1;
    tick();
    bus_ready      = 1'b0;
    flush          = 1'b1;
    bus_resp_valid = 1'b1;
    bus_rdata      = 32'h55AA55AA;
    #1;
    checkOutput("same_cycle_drop", 32'(resp_valid), 32'h0);
    tick();
    flush          = 1'b0;
    bus_resp_valid = 1'b0;

    // Flush in IDLE with both requesters valid.
    $display("[TB] flush in idle");
    applyStimulus(2'b11, 1'b1);
    expectGrant(1'b1, "flush_idle_exec");
    serviceBus(2'b01, 0, 32'h11112222, 1'b1);
    #2;
    expectGrant(1'b0, "fetch_after_idle_flush");
    serviceBus(2'b00, 0, 32'h33334444, 1'b1);

    // Reset in ISSUE, then a stray bus response.
    $display("[TB] reset mid-transaction");
    req_addr[0] = 32'h80;
    applyStimulus(2'b01, 1'b0);
    expectGrant(1'b0, "reset_fetch_grant");
    tick();
    req_valid = 2'b00;
    #1;
    checkOutput("reset_pre_valid", 32'(bus_valid), 32'h1);
    nreset = 1'b0;
    #1;
    checkOutput("reset_bus_valid", 32'(bus_valid), 32'h0);
    checkOutput("reset_bus_addr", bus_addr, 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_owner", 32'(owner), 32'h0);
    tick();
    nreset = 1'b1;
    tick();
    bus_resp_valid = 1'b1;
    bus_rdata      = 32'hFFFF0000;
    #1;
    checkOutput("stray_resp", 32'(resp_valid), 32'h0);
    checkOutput("stray_busy", 32'(busy), 32'h0);
    tick();
    bus_resp_valid = 1'b0;
    tick();

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
